muxn_stream: RTL
================

# muxn_stream

Parametrised N-input, WIDTH-bit stream multiplexer with valid/ready handshakes on every input and on the output. It adds a registered output stage, so a transfer appears at the output one cycle after it is accepted. Source choice is either fixed by a select input or round-robin among the requesting inputs. It is the next generation of the team's 2:1 data multiplexer and serves as the common selection stage in the coverage and verification example datapaths.

## Interface
- WIDTH, 8, data width of each input and of the output
- N, 4, number of input channels (N ≥ 2); SW = $clog2(N) is a derived localparam
- clk  input  1  rising-edge clock
- rst  input  1  reset; one clock, reset is synchronous and active-high
- mode  input  1  0 = fixed select via sel, 1 = round-robin
- sel  input  SW  selected channel index when mode = 0
- in_data  input  N*WIDTH  packed input data; channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready (combinational)
- y  output  WIDTH  registered output data
- y_valid  output  1  output valid (registered)
- y_ready  input  1  downstream ready
- y_src  output  SW  index of the channel that produced the current y (registered)

## Operation
- load = !y_valid || y_ready. The output register accepts new data whenever it is empty or is being drained in the same cycle.
- Grant, mode 0:
  - The granted channel is sel, provided sel < N and in_valid[sel] = 1.
  - Otherwise there is no grant.
  - Valid on any other channel is ignored and those channels stall.
- Grant, mode 1:
  - The search starts at index (last+1) mod N and ascends with wrap-around.
  - The first channel with in_valid = 1 is granted.
  - last holds the most recently granted index.
- in_ready[i] = load && granted && (grant == i). At most one in_ready bit is high in any cycle.
- Input transfer on channel i occurs when in_valid[i] && in_ready[i]. On the next edge:
  - y ← channel i data
  - y_src ← i
  - y_valid ← 1
  - last ← i, in both modes
- If load = 1 and there is no grant: y_valid ← 0 on the next edge. y and y_src keep their values.
- If load = 0 (y_valid = 1 and y_ready = 0):
  - y, y_src and y_valid hold.
  - All in_ready bits are 0.
- Output transfer occurs when y_valid && y_ready.
- A simultaneous output and input transfer in the same cycle is legal and sustains 1 word per cycle.
- A change of mode or sel applies to the next arbitration only. A word already in the output register is never dropped or replaced.
- Reset:
  - y = 0, y_valid = 0, y_src = 0.
  - last = N-1, so the first round-robin search starts at channel 0.
  - in_ready = 0 while rst = 1.
- Asserting rst mid-operation discards the held output word. No input transfer is counted during a reset cycle.
- Inputs are expected to obey AXI-style rules: once valid is asserted, data stays stable until accepted. The block does not check this.

## Timing
- Latency: 1 cycle from the input transfer edge to y_valid = 1 with the matching y.
- Throughput: 1 word per cycle while y_ready = 1 and a grant exists.
- in_ready depends combinationally on y_ready, y_valid, in_valid, mode, sel and last.
- There is no combinational path from in_data to y.
- Round-robin fairness: with all N channels continuously valid and y_ready = 1, each channel is granted exactly once in every N consecutive transfers.

## Configuration
- Macro MUXN_STREAM_XFER_CNT_EN.
- When defined, the block adds the port xfer_cnt  output  16  count of output transfers.
  - xfer_cnt resets to 0.
  - It increments by 1 on each y_valid && y_ready edge.
  - It saturates at 16'hFFFF.
- When undefined, the port and its logic are absent. All other behaviour is identical.

## Test plan
1. Reset and idle:
   - Stimulus: rst = 1 for 2 cycles, then in_valid = 0.
   - Required: y = 0, y_valid = 0, y_src = 0, in_ready = 0 throughout. xfer_cnt = 0 when MUXN_STREAM_XFER_CNT_EN is defined.
2. Fixed select:
   - Setup: mode = 0, sel = 2, y_ready = 1, all in_valid = 1, channel data 8'h10/8'h21/8'h32/8'h43.
   - Required: only in_ready[2] = 1. One cycle later y = 8'h32, y_src = 2, y_valid = 1.
   - Then sel = 3 with in_valid[3] = 0: y_valid drops to 0 on the next edge.
3. Round-robin fairness:
   - Setup: mode = 1, all in_valid = 1, y_ready = 1, starting from reset.
   - Required: y_src sequence is 0,1,2,3,0,1,2,3.
   - Then with only channels 1 and 3 valid: the grants alternate 1,3,1,3.
4. Backpressure:
   - Stimulus: y holds 8'hA5 and y_ready = 0 for 3 cycles.
   - Required during the hold: y = 8'hA5 and y_valid = 1 stay stable, all in_ready = 0, last is unchanged.
   - Required when y_ready returns to 1: a new word is loaded on the same edge as the drain, with no bubble.
5. Reset mid-stream:
   - Stimulus: rst = 1 for one cycle during a back-to-back round-robin stream while y_valid = 1.
   - Required: the next cycle shows y_valid = 0 and y = 0.
   - Required after release with all channels valid: the first grant is channel 0.
6. Counter saturation (MUXN_STREAM_XFER_CNT_EN defined):
   - Stimulus: force the count near its maximum and perform 3 output transfers starting at 16'hFFFE.
   - Required: xfer_cnt reads FFFE → FFFF → FFFF.

Source files
------------

// File: rtl/muxn_stream.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// muxn_stream
//
// N-input, WIDTH-bit stream multiplexer. Every input and the output use a
// valid/ready handshake. One output register sits between the inputs and the
// output, so a word appears at y one cycle after its input transfer. There is
// no combinational path from in_data to y.
//
// The source is chosen in one of two ways:
//   mode = 0 : fixed select. Channel sel is granted when it is valid. Every
//              other channel stalls.
//   mode = 1 : round-robin. The search starts at (last + 1) mod N and wraps.
//              last is the most recently granted channel, whichever mode
//              granted it.
//
// Parameters
//   WIDTH     data width of each channel and of y
//   N         number of input channels (N >= 2); SW = $clog2(N)
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   mode      0 = fixed select, 1 = round-robin
//   sel       channel index used when mode = 0
//   in_data   packed channel data; channel i is in_data[i*WIDTH +: WIDTH]
//   in_valid  per-channel valid
//   in_ready  per-channel ready (combinational, at most one bit high)
//   y         registered output data
//   y_valid   registered output valid
//   y_ready   downstream ready
//   y_src     registered index of the channel that produced y
//   xfer_cnt  saturating 16-bit count of output transfers. This port exists
//             only when MUXN_STREAM_XFER_CNT_EN is defined.
//
// Optional feature macro: MUXN_STREAM_XFER_CNT_EN
// -----------------------------------------------------------------------------
module muxn_stream #(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    localparam int SW    = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SW-1:0]      sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   y,
    output logic               y_valid,
    input  logic               y_ready,
    output logic [SW-1:0]      y_src
`ifdef MUXN_STREAM_XFER_CNT_EN
    ,
    output logic [15:0]        xfer_cnt
`endif
);

    logic             load;        // the output register may take a word this cycle
    logic             granted;     // some channel wins arbitration this cycle
    logic [SW-1:0]    grant_idx;   // the winning channel
    logic [WIDTH-1:0] grant_data;  // data of the winning channel
    logic [SW-1:0]    last;        // most recently granted channel

    // The register is empty, or its current word leaves on this edge.
    assign load = !y_valid || y_ready;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    always_comb begin : arbitrate
        int            cand;
        logic [SW-1:0] cand_idx;
        // NOTE: every variable written here gets a default before any branch,
        // so no path can leave a value unassigned. That rules out inferred latches.
        granted   = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;

        if (!mode) begin
            for (int i = 0; i < N; i++) begin
                if (sel == SW'(i) && in_valid[i]) begin
                    granted   = 1'b1;
                    grant_idx = SW'(i);
                end
            end
        end else begin
            // Walk the offsets from lowest priority (N) to highest priority (1).
            // A later hit overwrites an earlier one, so the nearest valid
            // channel after last is the one that wins.
            for (int k = N; k >= 1; k--) begin
                cand = int'(last) + k;
                if (cand >= N) begin
                    cand = cand - N;
                end
                cand_idx = SW'(cand);
                if (in_valid[cand_idx]) begin
                    granted   = 1'b1;
                    grant_idx = cand_idx;
                end
            end
        end
    end

    // Handshake back to the sources, and the data mux into the register.
    always_comb begin : steer
        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SW'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = !rst && load && granted;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output register and round-robin pointer
    // -------------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=) only. Every
    // register then samples the values from before the edge, whatever order
    // the statements are in.
    always_ff @(posedge clk) begin
        if (rst) begin
            y       <= '0;
            y_valid <= 1'b0;
            y_src   <= '0;
            last    <= SW'(N - 1);  // the first round-robin search starts at channel 0
        end else if (load) begin
            if (granted) begin
                y       <= grant_data;
                y_src   <= grant_idx;
                y_valid <= 1'b1;
                last    <= grant_idx;
            end else begin
                // The register is empty now; y and y_src keep their stale contents.
                y_valid <= 1'b0;
            end
        end
    end

`ifdef MUXN_STREAM_XFER_CNT_EN
    // -------------------------------------------------------------------------
    // Output transfer counter, saturating at 16'hFFFF
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt <= '0;
        end else if (y_valid && y_ready && xfer_cnt != 16'hFFFF) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end
`endif

endmodule
